// File: rtl/wb_stage_buf_if.sv
// Bundle of the memory-stage entry, register-file write, bypass query and
// debug trace signals around the writeback buffer.
interface wb_stage_buf_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int WE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ms_to_ws_valid;
    logic [WE_W-1:0]   ms_gr_we;
    logic [4:0]        ms_dest;
    logic [DATA_W-1:0] ms_result;
    logic [31:0]       ms_pc;
    logic              ws_allowin;

    logic              rf_ready;
    logic [WE_W-1:0]   rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [4:0]        fwd_raddr;
    logic              fwd_hit;
    logic              fwd_full;
    logic [DATA_W-1:0] fwd_data;

    logic              ws_is_valid;
    logic [CNT_W-1:0]  ws_count;

    logic [31:0]       debug_wb_pc;
    logic [WE_W-1:0]   debug_wb_rf_wen;
    logic [4:0]        debug_wb_rf_wnum;
    logic [DATA_W-1:0] debug_wb_rf_wdata;

    modport slave (
        input  ms_to_ws_valid, ms_gr_we, ms_dest, ms_result, ms_pc,
        input  rf_ready, fwd_raddr,
        output ws_allowin, rf_we, rf_waddr, rf_wdata,
        output fwd_hit, fwd_full, fwd_data, ws_is_valid, ws_count,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport master (
        output ms_to_ws_valid, ms_gr_we, ms_dest, ms_result, ms_pc,
        output rf_ready, fwd_raddr,
        input  ws_allowin, rf_we, rf_waddr, rf_wdata,
        input  fwd_hit, fwd_full, fwd_data, ws_is_valid, ws_count,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage_buf.sv
// Writeback buffer: circular FIFO of results draining into the register file,
// with youngest-match bypass lookup for decode.
module wb_stage_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic           clk,
    input  logic           resetn,
    wb_stage_buf_if.slave  bus
);
    localparam int WE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WE_W-1:0]   r_we     [DEPTH];
    logic [4:0]        r_dest   [DEPTH];
    logic [DATA_W-1:0] r_result [DEPTH];
    logic [31:0]       r_pc     [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_head_valid;
    logic              w_commit;
    logic              w_push;
    logic [WE_W-1:0]   w_head_we;
    logic [WE_W-1:0]   w_rf_we;

    logic              w_fwd_hit;
    logic [WE_W-1:0]   w_fwd_we;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]  w_idx;

    assign w_head_valid   = (r_count != '0);
    assign w_head_we      = r_we[r_head];
    // Strobe-less entries retire without waiting on the register file.
    assign w_commit       = w_head_valid && (bus.rf_ready || (w_head_we == '0));
    assign bus.ws_allowin = (r_count < CNT_W'(DEPTH)) || w_commit;
    assign w_push         = bus.ms_to_ws_valid && bus.ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)   r_tail <= r_tail + PTR_W'(1);
            if (w_commit) r_head <= r_head + PTR_W'(1);
            case ({w_push, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we[r_tail]     <= bus.ms_gr_we;
            r_dest[r_tail]   <= bus.ms_dest;
            r_result[r_tail] <= bus.ms_result;
            r_pc[r_tail]     <= bus.ms_pc;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_we   = '0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (bus.fwd_raddr != 5'd0) &&
                (r_dest[w_idx] == bus.fwd_raddr) && (r_we[w_idx] != '0)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_we   = r_we[w_idx];
                w_fwd_data = r_result[w_idx];
            end
        end
    end

    assign w_rf_we      = w_head_valid ? w_head_we : '0;
    assign bus.rf_we    = w_rf_we;
    assign bus.rf_waddr = w_head_valid ? r_dest[r_head] : 5'd0;
    assign bus.rf_wdata = w_head_valid ? r_result[r_head] : '0;

    assign bus.fwd_hit  = w_fwd_hit;
    assign bus.fwd_full = w_fwd_hit && (&w_fwd_we);
    assign bus.fwd_data = w_fwd_data;

    assign bus.ws_is_valid = w_head_valid;
    assign bus.ws_count    = r_count;

    assign bus.debug_wb_pc       = w_head_valid ? r_pc[r_head] : 32'd0;
    assign bus.debug_wb_rf_wen   = w_commit ? w_rf_we : '0;
    assign bus.debug_wb_rf_wnum  = w_head_valid ? r_dest[r_head] : 5'd0;
    assign bus.debug_wb_rf_wdata = w_head_valid ? r_result[r_head] : '0;
endmodule

// File: tb/tb_wb_stage_buf.sv
// Randomized bench for wb_stage_buf against a queue-based model, plus
// directed cases with hand-computed expectations.
module tb_wb_stage_buf;
    localparam int DW   = 32;
    localparam int DP   = 2;
    localparam int WE_W = DW / 8;

    logic clk;
    logic resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_stage_buf_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    wb_stage_buf #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WE_W-1:0] we;
        logic [4:0]      dest;
        logic [DW-1:0]   res;
        logic [31:0]     pc;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: queue of held entries, updated on each edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
        end else begin
            automatic bit   c = (q.size() != 0) && (bus.rf_ready || q[0].we == '0);
            automatic bit   p = bus.ms_to_ws_valid && ((q.size() < DP) || c);
            automatic ent_t e;
            e.we = bus.ms_gr_we; e.dest = bus.ms_dest; e.res = bus.ms_result; e.pc = bus.ms_pc;
            if (c) void'(q.pop_front());
            if (p) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        automatic bit              hv = (q.size() != 0);
        automatic bit              c  = hv && (bus.rf_ready || q[0].we == '0);
        automatic logic [WE_W-1:0] xwe = hv ? q[0].we : '0;
        automatic bit              hit = 1'b0;
        automatic logic [WE_W-1:0] fwe = '0;
        automatic logic [DW-1:0]   fdat = '0;
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (!hit && bus.fwd_raddr != 5'd0 && q[j].dest == bus.fwd_raddr && q[j].we != '0) begin
                hit = 1'b1; fwe = q[j].we; fdat = q[j].res;
            end
        end
        chk("allowin",    bus.ws_allowin, (q.size() < DP) || c);
        chk("is_valid",   bus.ws_is_valid, hv);
        chk("count",      bus.ws_count, q.size());
        chk("rf_we",      bus.rf_we, xwe);
        chk("rf_waddr",   bus.rf_waddr, hv ? q[0].dest : 5'd0);
        chk("rf_wdata",   bus.rf_wdata, hv ? q[0].res : '0);
        chk("fwd_hit",    bus.fwd_hit, hit);
        chk("fwd_full",   bus.fwd_full, hit && (&fwe));
        chk("fwd_data",   bus.fwd_data, fdat);
        chk("dbg_pc",     bus.debug_wb_pc, hv ? q[0].pc : 32'd0);
        chk("dbg_wen",    bus.debug_wb_rf_wen, c ? xwe : '0);
        chk("dbg_wnum",   bus.debug_wb_rf_wnum, hv ? q[0].dest : 5'd0);
        chk("dbg_wdata",  bus.debug_wb_rf_wdata, hv ? q[0].res : '0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [WE_W-1:0] we, input logic [4:0] d,
                       input logic [DW-1:0] r, input logic [31:0] pc);
        bus.ms_to_ws_valid = 1'b1;
        bus.ms_gr_we = we; bus.ms_dest = d; bus.ms_result = r; bus.ms_pc = pc;
    endtask

    task automatic drain();
        int n = 0;
        bus.ms_to_ws_valid = 1'b0;
        bus.rf_ready = 1'b1;
        while (bus.ws_count != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("drain_timeout", bus.ws_count, 0);
    endtask

    initial begin
        resetn = 1'b0;
        bus.ms_to_ws_valid = 1'b0; bus.ms_gr_we = '0; bus.ms_dest = '0;
        bus.ms_result = '0; bus.ms_pc = '0; bus.rf_ready = 1'b0; bus.fwd_raddr = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_allowin", bus.ws_allowin, 1);
        chk("rst_valid",   bus.ws_is_valid, 0);
        chk("rst_count",   bus.ws_count, 0);
        chk("rst_rf_we",   bus.rf_we, 0);

        // Single write with register file ready; first edge after reset accepts.
        cyc();
        resetn = 1'b1;
        bus.rf_ready = 1'b1;
        put(4'hF, 5'd5, 32'h12345678, 32'hBFC00000);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        @(negedge clk);
        chk("d1_rf_we",   bus.rf_we, 4'hF);
        chk("d1_waddr",   bus.rf_waddr, 5);
        chk("d1_wdata",   bus.rf_wdata, 32'h12345678);
        chk("d1_pc",      bus.debug_wb_pc, 32'hBFC00000);
        chk("d1_dbg_wen", bus.debug_wb_rf_wen, 4'hF);
        cyc();
        @(negedge clk);
        chk("d1_empty",   bus.ws_is_valid, 0);

        // Fill, then pop and push in the same cycle.
        cyc();
        bus.rf_ready = 1'b0;
        put(4'hF, 5'd1, 32'h11, 32'h100);
        cyc();
        put(4'hF, 5'd2, 32'h22, 32'h104);
        cyc();
        put(4'hF, 5'd4, 32'h44, 32'h108);
        @(negedge clk);
        chk("d2_full_allowin", bus.ws_allowin, 0);
        chk("d2_full_count",   bus.ws_count, 2);
        cyc();
        bus.rf_ready = 1'b1;
        @(negedge clk);
        chk("d2_commit_allowin", bus.ws_allowin, 1);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        bus.rf_ready = 1'b0;
        @(negedge clk);
        chk("d2_count_kept", bus.ws_count, 2);
        chk("d2_head",       bus.rf_waddr, 2);
        drain();

        // No-strobe entry retires even with register file stalled.
        bus.rf_ready = 1'b0;
        put(4'h0, 5'd7, 32'h77, 32'h200);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        @(negedge clk);
        chk("d3_valid",   bus.ws_is_valid, 1);
        chk("d3_dbg_wen", bus.debug_wb_rf_wen, 0);
        cyc();
        @(negedge clk);
        chk("d3_popped",  bus.ws_count, 0);

        // Youngest match wins the bypass.
        cyc();
        put(4'hF, 5'd3, 32'hAAAA0000, 32'h300);
        cyc();
        put(4'hF, 5'd3, 32'hBBBB0000, 32'h304);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        bus.fwd_raddr = 5'd3;
        @(negedge clk);
        chk("d4_hit",  bus.fwd_hit, 1);
        chk("d4_full", bus.fwd_full, 1);
        chk("d4_data", bus.fwd_data, 32'hBBBB0000);
        #1 bus.fwd_raddr = 5'd0;
        #1 chk("d4_r0_hit", bus.fwd_hit, 0);
        drain();

        // Partial strobes hit but are not full.
        bus.rf_ready = 1'b0;
        put(4'h3, 5'd9, 32'h00001234, 32'h400);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        bus.fwd_raddr = 5'd9;
        @(negedge clk);
        chk("d5_hit",  bus.fwd_hit, 1);
        chk("d5_full", bus.fwd_full, 0);
        drain();

        // Asynchronous reset with entries held.
        bus.rf_ready = 1'b0;
        put(4'hF, 5'd10, 32'hA0, 32'h500);
        cyc();
        put(4'hF, 5'd11, 32'hB0, 32'h504);
        cyc();
        bus.ms_to_ws_valid = 1'b0;
        @(negedge clk);
        chk("d6_pre_count", bus.ws_count, 2);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("d6_count",   bus.ws_count, 0);
        chk("d6_rf_we",   bus.rf_we, 0);
        chk("d6_dbg_wen", bus.debug_wb_rf_wen, 0);
        cyc();
        resetn = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            automatic int unsigned k = $urandom_range(0, 4);
            bus.ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            case (k)
                0: bus.ms_gr_we = 4'h0;
                1: bus.ms_gr_we = 4'hF;
                2: bus.ms_gr_we = 4'h3;
                default: bus.ms_gr_we = 4'($urandom);
            endcase
            bus.ms_dest   = 5'($urandom_range(0, 7));
            bus.ms_result = $urandom;
            bus.ms_pc     = $urandom;
            bus.rf_ready  = ($urandom_range(0, 2) != 0);
            bus.fwd_raddr = 5'($urandom_range(0, 7));
            if (i % 800 == 400) begin
                @(posedge clk);
                #3 resetn = 1'b0;
                cyc();
                resetn = 1'b1;
            end else begin
                cyc();
            end
        end
        drain();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
